// File: rtl/rvfi_retire_buffer.sv
// Retirement reorder buffer feeding a single-channel RVFI packet stream.
// Instructions are allocated in program order, completed out of order by
// tag, and retired in order with a free-running 8-bit rvfi_order.
module rvfi_retire_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAGW  = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [TAGW-1:0]     alloc_tag,
  input  logic [31:0]         alloc_insn,
  input  logic [XLEN-1:0]     alloc_pc,
  input  logic                cmpl_valid,
  input  logic [TAGW-1:0]     cmpl_tag,
  input  logic [4:0]          cmpl_rs1_addr,
  input  logic [4:0]          cmpl_rs2_addr,
  input  logic [4:0]          cmpl_rd_addr,
  input  logic [XLEN-1:0]     cmpl_rs1_rdata,
  input  logic [XLEN-1:0]     cmpl_rs2_rdata,
  input  logic [XLEN-1:0]     cmpl_rd_wdata,
  input  logic [XLEN-1:0]     cmpl_post_pc,
  input  logic [XLEN-1:0]     cmpl_mem_addr,
  input  logic [XLEN-1:0]     cmpl_mem_rdata,
  input  logic [XLEN-1:0]     cmpl_mem_wdata,
  input  logic [XLEN/8-1:0]   cmpl_mem_rmask,
  input  logic [XLEN/8-1:0]   cmpl_mem_wmask,
  input  logic                cmpl_trap,
  output logic                rvfi_valid,
  output logic [7:0]          rvfi_order,
  output logic [31:0]         rvfi_insn,
  output logic [XLEN-1:0]     rvfi_pre_pc,
  output logic [XLEN-1:0]     rvfi_post_pc,
  output logic [XLEN-1:0]     rvfi_rs1_rdata,
  output logic [XLEN-1:0]     rvfi_rs2_rdata,
  output logic [XLEN-1:0]     rvfi_rd_wdata,
  output logic [XLEN-1:0]     rvfi_mem_addr,
  output logic [XLEN-1:0]     rvfi_mem_rdata,
  output logic [XLEN-1:0]     rvfi_mem_wdata,
  output logic [4:0]          rvfi_rs1_addr,
  output logic [4:0]          rvfi_rs2_addr,
  output logic [4:0]          rvfi_rd_addr,
  output logic [XLEN/8-1:0]   rvfi_mem_rmask,
  output logic [XLEN/8-1:0]   rvfi_mem_wmask,
  output logic                rvfi_trap,
  output logic                err
);

  localparam int unsigned MASKW = XLEN / 8;
  localparam int unsigned CNTW  = TAGW + 1;

  typedef struct packed {
    logic [31:0]       insn;
    logic [XLEN-1:0]   pre_pc;
    logic [XLEN-1:0]   post_pc;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [MASKW-1:0]  mem_rmask;
    logic [MASKW-1:0]  mem_wmask;
    logic              trap;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_e;

  // busy = PENDING or DONE; done distinguishes the two. FREE = !busy.
  logic [DEPTH-1:0] busy_q, done_q, busy_nxt, done_nxt;
  logic [TAGW-1:0]  head_q, tail_q, head_nxt, tail_nxt;
  logic [CNTW-1:0]  count_q, count_nxt;
  logic [7:0]       order_q;
  logic             ready_q;
  logic             do_alloc, do_retire, cmpl_hit, cmpl_bad;

  assign alloc_ready = ready_q;
  assign alloc_tag   = tail_q;
  assign head_e      = mem[head_q];

  // Handshake decode and next-state of the entry bookkeeping.
  always_comb begin
    do_alloc  = alloc_valid & ready_q & ~flush;
    do_retire = busy_q[head_q] & done_q[head_q] & ~flush;
    cmpl_hit  = cmpl_valid & ~flush & busy_q[cmpl_tag] & ~done_q[cmpl_tag];
    cmpl_bad  = cmpl_valid & ~flush & ~cmpl_hit;
    busy_nxt  = busy_q;
    done_nxt  = done_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    count_nxt = count_q;
    if (flush) begin
      busy_nxt  = '0;
      done_nxt  = '0;
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (do_retire) begin
        busy_nxt[head_q] = 1'b0;
        done_nxt[head_q] = 1'b0;
        head_nxt         = head_q + TAGW'(1);
      end
      if (do_alloc) begin
        busy_nxt[tail_q] = 1'b1;
        done_nxt[tail_q] = 1'b0;
        tail_nxt         = tail_q + TAGW'(1);
      end
      if (cmpl_hit) begin
        done_nxt[cmpl_tag] = 1'b1;
      end
      case ({do_alloc, do_retire})
        2'b10:   count_nxt = count_q + CNTW'(1);
        2'b01:   count_nxt = count_q - CNTW'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Control state, order counter, sticky error and the registered RVFI packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ready_q        <= 1'b0;
      order_q        <= '0;
      err            <= 1'b0;
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_pre_pc    <= '0;
      rvfi_post_pc   <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      rvfi_trap      <= 1'b0;
    end else begin
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      head_q     <= head_nxt;
      tail_q     <= tail_nxt;
      count_q    <= count_nxt;
      ready_q    <= (count_nxt < CNTW'(DEPTH));
      err        <= err | cmpl_bad;
      rvfi_valid <= do_retire;
      if (do_retire) begin
        order_q        <= order_q + 8'd1;
        rvfi_order     <= order_q;
        rvfi_insn      <= head_e.insn;
        rvfi_pre_pc    <= head_e.pre_pc;
        rvfi_post_pc   <= head_e.post_pc;
        rvfi_rs1_rdata <= head_e.rs1_rdata;
        rvfi_rs2_rdata <= head_e.rs2_rdata;
        rvfi_mem_addr  <= head_e.mem_addr;
        rvfi_mem_rdata <= head_e.mem_rdata;
        rvfi_mem_wdata <= head_e.mem_wdata;
        rvfi_rs1_addr  <= head_e.rs1_addr;
        rvfi_rs2_addr  <= head_e.rs2_addr;
        rvfi_trap      <= head_e.trap;
        rvfi_rd_addr   <= head_e.trap ? 5'd0 : head_e.rd_addr;
        rvfi_rd_wdata  <= (head_e.trap || head_e.rd_addr == 5'd0) ? '0 : head_e.rd_wdata;
        rvfi_mem_rmask <= head_e.trap ? '0 : head_e.mem_rmask;
        rvfi_mem_wmask <= head_e.trap ? '0 : head_e.mem_wmask;
      end
    end
  end

  // Entry payload storage; only read once the entry is DONE, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      mem[tail_q].insn   <= alloc_insn;
      mem[tail_q].pre_pc <= alloc_pc;
    end
    if (cmpl_hit) begin
      mem[cmpl_tag].post_pc   <= cmpl_post_pc;
      mem[cmpl_tag].rs1_rdata <= cmpl_rs1_rdata;
      mem[cmpl_tag].rs2_rdata <= cmpl_rs2_rdata;
      mem[cmpl_tag].rd_wdata  <= cmpl_rd_wdata;
      mem[cmpl_tag].mem_addr  <= cmpl_mem_addr;
      mem[cmpl_tag].mem_rdata <= cmpl_mem_rdata;
      mem[cmpl_tag].mem_wdata <= cmpl_mem_wdata;
      mem[cmpl_tag].rs1_addr  <= cmpl_rs1_addr;
      mem[cmpl_tag].rs2_addr  <= cmpl_rs2_addr;
      mem[cmpl_tag].rd_addr   <= cmpl_rd_addr;
      mem[cmpl_tag].mem_rmask <= cmpl_mem_rmask;
      mem[cmpl_tag].mem_wmask <= cmpl_mem_wmask;
      mem[cmpl_tag].trap      <= cmpl_trap;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Randomized bench for rvfi_retire_buffer against a program-order queue model.
module tb_rvfi_retire_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAGW  = 3;
  localparam int unsigned MASKW = XLEN / 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAGW-1:0]   alloc_tag;
  logic [31:0]       alloc_insn;
  logic [XLEN-1:0]   alloc_pc;
  logic              cmpl_valid;
  logic [TAGW-1:0]   cmpl_tag;
  logic [4:0]        cmpl_rs1_addr, cmpl_rs2_addr, cmpl_rd_addr;
  logic [XLEN-1:0]   cmpl_rs1_rdata, cmpl_rs2_rdata, cmpl_rd_wdata, cmpl_post_pc;
  logic [XLEN-1:0]   cmpl_mem_addr, cmpl_mem_rdata, cmpl_mem_wdata;
  logic [MASKW-1:0]  cmpl_mem_rmask, cmpl_mem_wmask;
  logic              cmpl_trap;
  logic              rvfi_valid;
  logic [7:0]        rvfi_order;
  logic [31:0]       rvfi_insn;
  logic [XLEN-1:0]   rvfi_pre_pc, rvfi_post_pc, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [XLEN-1:0]   rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4:0]        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [MASKW-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic              rvfi_trap;
  logic              err;

  rvfi_retire_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_insn(alloc_insn), .alloc_pc(alloc_pc),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .cmpl_rs1_addr(cmpl_rs1_addr), .cmpl_rs2_addr(cmpl_rs2_addr), .cmpl_rd_addr(cmpl_rd_addr),
    .cmpl_rs1_rdata(cmpl_rs1_rdata), .cmpl_rs2_rdata(cmpl_rs2_rdata),
    .cmpl_rd_wdata(cmpl_rd_wdata), .cmpl_post_pc(cmpl_post_pc),
    .cmpl_mem_addr(cmpl_mem_addr), .cmpl_mem_rdata(cmpl_mem_rdata),
    .cmpl_mem_wdata(cmpl_mem_wdata), .cmpl_mem_rmask(cmpl_mem_rmask),
    .cmpl_mem_wmask(cmpl_mem_wmask), .cmpl_trap(cmpl_trap),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_post_pc(rvfi_post_pc),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_trap(rvfi_trap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    bit               done;
    logic [31:0]      insn;
    logic [XLEN-1:0]  pre_pc, post_pc, rs1_rdata, rs2_rdata, rd_wdata;
    logic [XLEN-1:0]  mem_addr, mem_rdata, mem_wdata;
    logic [4:0]       rs1_addr, rs2_addr, rd_addr;
    logic [MASKW-1:0] rmask, wmask;
    bit               trap;
  } rec_t;

  rec_t q[$];
  rec_t exp_pkt;
  bit   exp_valid;
  int   exp_order;
  int   m_order;
  int   m_tail;
  bit   m_err;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference model, using the inputs presented this cycle.
  task automatic model_step();
    bit ret;
    bit rdy;
    int idx;
    rec_t r;
    if (flush) begin
      q.delete();
      m_tail    = 0;
      exp_valid = 0;
      return;
    end
    ret = (q.size() > 0) && q[0].done;
    rdy = q.size() < DEPTH;
    if (cmpl_valid) begin
      idx = -1;
      foreach (q[i]) if (q[i].tag == int'(cmpl_tag)) idx = i;
      if (idx >= 0 && !q[idx].done) begin
        q[idx].done      = 1;
        q[idx].post_pc   = cmpl_post_pc;
        q[idx].rs1_rdata = cmpl_rs1_rdata;
        q[idx].rs2_rdata = cmpl_rs2_rdata;
        q[idx].rd_wdata  = cmpl_rd_wdata;
        q[idx].mem_addr  = cmpl_mem_addr;
        q[idx].mem_rdata = cmpl_mem_rdata;
        q[idx].mem_wdata = cmpl_mem_wdata;
        q[idx].rs1_addr  = cmpl_rs1_addr;
        q[idx].rs2_addr  = cmpl_rs2_addr;
        q[idx].rd_addr   = cmpl_rd_addr;
        q[idx].rmask     = cmpl_mem_rmask;
        q[idx].wmask     = cmpl_mem_wmask;
        q[idx].trap      = cmpl_trap;
      end else begin
        m_err = 1;
      end
    end
    exp_valid = ret;
    if (ret) begin
      exp_pkt   = q.pop_front();
      exp_order = m_order;
      m_order   = (m_order + 1) % 256;
    end
    if (alloc_valid && rdy) begin
      r        = '{default: '0};
      r.tag    = m_tail;
      r.insn   = alloc_insn;
      r.pre_pc = alloc_pc;
      q.push_back(r);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // Compare every observable output with the model; packet fields hold when idle.
  task automatic check_all();
    bit tr;
    tr = exp_pkt.trap;
    check("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
    check("alloc_tag",   64'(alloc_tag),   64'(m_tail));
    check("rvfi_valid",  64'(rvfi_valid),  64'(exp_valid));
    check("rvfi_order",  64'(rvfi_order),  64'(exp_order));
    check("rvfi_insn",   64'(rvfi_insn),   64'(exp_pkt.insn));
    check("rvfi_pre_pc", 64'(rvfi_pre_pc), 64'(exp_pkt.pre_pc));
    check("rvfi_post_pc", 64'(rvfi_post_pc), 64'(exp_pkt.post_pc));
    check("rvfi_rs1_addr", 64'(rvfi_rs1_addr), 64'(exp_pkt.rs1_addr));
    check("rvfi_rs2_addr", 64'(rvfi_rs2_addr), 64'(exp_pkt.rs2_addr));
    check("rvfi_rs1_rdata", 64'(rvfi_rs1_rdata), 64'(exp_pkt.rs1_rdata));
    check("rvfi_rs2_rdata", 64'(rvfi_rs2_rdata), 64'(exp_pkt.rs2_rdata));
    check("rvfi_rd_addr", 64'(rvfi_rd_addr), tr ? 64'(0) : 64'(exp_pkt.rd_addr));
    check("rvfi_rd_wdata", 64'(rvfi_rd_wdata),
          (tr || exp_pkt.rd_addr == 5'd0) ? 64'(0) : 64'(exp_pkt.rd_wdata));
    check("rvfi_mem_addr",  64'(rvfi_mem_addr),  64'(exp_pkt.mem_addr));
    check("rvfi_mem_rdata", 64'(rvfi_mem_rdata), 64'(exp_pkt.mem_rdata));
    check("rvfi_mem_wdata", 64'(rvfi_mem_wdata), 64'(exp_pkt.mem_wdata));
    check("rvfi_mem_rmask", 64'(rvfi_mem_rmask), tr ? 64'(0) : 64'(exp_pkt.rmask));
    check("rvfi_mem_wmask", 64'(rvfi_mem_wmask), tr ? 64'(0) : 64'(exp_pkt.wmask));
    check("rvfi_trap", 64'(rvfi_trap), 64'(tr));
    check("err", 64'(err), 64'(m_err));
  endtask

  // Present one cycle of stimulus (inputs change on the falling edge), then check.
  task automatic drive(input bit a, input bit c, input int tag, input bit trap,
                       input bit rd0, input bit f);
    alloc_valid    = a;
    alloc_insn     = $urandom;
    alloc_pc       = XLEN'($urandom) & ~XLEN'(3);
    cmpl_valid     = c;
    cmpl_tag       = TAGW'(tag);
    cmpl_rs1_addr  = 5'($urandom);
    cmpl_rs2_addr  = 5'($urandom);
    cmpl_rd_addr   = rd0 ? 5'd0 : 5'($urandom);
    cmpl_rs1_rdata = $urandom;
    cmpl_rs2_rdata = $urandom;
    cmpl_rd_wdata  = rd0 ? XLEN'(32'hDEADBEEF) : XLEN'($urandom);
    cmpl_post_pc   = $urandom;
    cmpl_mem_addr  = $urandom;
    cmpl_mem_rdata = $urandom;
    cmpl_mem_wdata = $urandom;
    cmpl_mem_rmask = MASKW'($urandom);
    cmpl_mem_wmask = trap ? MASKW'(4'hF) : MASKW'($urandom);
    cmpl_trap      = trap;
    flush          = f;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic int pick_pending();
    int idx[$];
    foreach (q[i]) if (!q[i].done) idx.push_back(i);
    if (idx.size() == 0) return -1;
    return q[idx[$urandom_range(0, idx.size() - 1)]].tag;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int t;
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      t = pick_pending();
      drive(0, t >= 0, (t >= 0) ? t : 0, 0, 0, 0);
    end
    idle(2);
  endtask

  initial begin
    int t;
    int a_pct;
    int c_pct;
    resetn    = 1'b0;
    exp_pkt   = '{default: '0};
    exp_valid = 0;
    exp_order = 0;
    m_order   = 0;
    m_tail    = 0;
    m_err     = 0;
    alloc_valid = 0; alloc_insn = '0; alloc_pc = '0;
    cmpl_valid = 0; cmpl_tag = '0; cmpl_trap = 0; flush = 0;
    cmpl_rs1_addr = '0; cmpl_rs2_addr = '0; cmpl_rd_addr = '0;
    cmpl_rs1_rdata = '0; cmpl_rs2_rdata = '0; cmpl_rd_wdata = '0; cmpl_post_pc = '0;
    cmpl_mem_addr = '0; cmpl_mem_rdata = '0; cmpl_mem_wdata = '0;
    cmpl_mem_rmask = '0; cmpl_mem_wmask = '0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("reset rvfi_valid", 64'(rvfi_valid), 64'(0));
    check("reset rvfi_order", 64'(rvfi_order), 64'(0));
    check("reset rvfi_pre_pc", 64'(rvfi_pre_pc), 64'(0));
    check("reset err", 64'(err), 64'(0));
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all();

    // In-order: alloc 0,1,2 then complete 0,1,2 back to back.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, i, 0, 0, 0);
    idle(3);

    // Out-of-order: alloc four, complete newest first.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) drive(0, 1, q[i].tag, 0, 0, 0);
    idle(6);

    // Fill to DEPTH, extra alloc attempts, then free the head with alloc held high.
    for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, q[0].tag, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    drain();

    // Flush with 5 in flight (2 done, head still pending); order must continue.
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, q[2].tag, 0, 0, 0);
    drive(0, 1, q[4].tag, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, q[0].tag, 0, 0, 0);
    idle(2);

    // Field rules: rd=0 with DEADBEEF, then a trap with a full write mask.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, q[0].tag, 0, 1, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, q[0].tag, 1, 0, 0);
    idle(2);

    // Random traffic with varying alloc/complete pressure; order wraps many times.
    for (int seg = 0; seg < 20; seg++) begin
      a_pct = $urandom_range(20, 95);
      c_pct = $urandom_range(20, 95);
      for (int i = 0; i < 200; i++) begin
        t = pick_pending();
        drive(($urandom_range(0, 99) < a_pct),
              (t >= 0) && ($urandom_range(0, 99) < c_pct),
              (t >= 0) ? t : 0,
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 199) == 0));
      end
    end
    drain();

    // Completing a FREE tag raises err; it survives later traffic and flush.
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 5, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, q[0].tag, 0, 0, 0);
    drive(0, 1, m_tail == 0 ? 7 : m_tail - 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_buffer.md
Name: rvfi_retire_buffer

Overview:
- Producer end of the RVFI retirement channel.
- Instructions are allocated in program order and completed out of order by tag.
- Emits a registered single-channel RVFI packet stream in strict program order, with a monotonically incrementing rvfi_order.
- Sits between a core's issue/writeback pipeline and any RVFI consumer: formal checkers, trace monitors.

Parameters:
- XLEN, 32, datapath width. Legal values 32 or 64.
- DEPTH, 8, number of in-flight entries. Power of two, 2..32.
- TAGW, 3, tag width. Must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all in-flight entries
- alloc_valid  in  1  allocate request
- alloc_ready  out  1  entry available, count < DEPTH
- alloc_tag  out  TAGW  tag granted on alloc handshake; equals tail pointer
- alloc_insn  in  32  instruction word
- alloc_pc  in  XLEN  pre-PC
- cmpl_valid  in  1  completion strobe
- cmpl_tag  in  TAGW  entry being completed
- cmpl_rs1_addr, cmpl_rs2_addr, cmpl_rd_addr  in  5 each
- cmpl_rs1_rdata, cmpl_rs2_rdata, cmpl_rd_wdata, cmpl_post_pc, cmpl_mem_addr, cmpl_mem_rdata, cmpl_mem_wdata  in  XLEN each
- cmpl_mem_rmask, cmpl_mem_wmask  in  XLEN/8 each
- cmpl_trap  in  1
- rvfi_valid  out  1  one retirement this cycle
- rvfi_order  out  8  retirement index
- rvfi_insn  out  32
- rvfi_pre_pc, rvfi_post_pc, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  XLEN each
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each
- rvfi_mem_rmask, rvfi_mem_wmask  out  XLEN/8 each
- rvfi_trap  out  1
- err  out  1  sticky protocol error

Behaviour:
- Reset (resetn low, asynchronous):
  - head, tail, count and all entry valid/done bits clear.
  - Order counter = 0.
  - All rvfi_* outputs = 0.
  - err = 0.
  - alloc_ready goes high in the first cycle after reset release.
- Entry state: each entry is FREE, PENDING or DONE.
- Alloc:
  - Handshake on alloc_valid && alloc_ready.
  - Entry[tail] becomes PENDING and stores insn and pc; tail increments mod DEPTH.
  - alloc_ready = (count < DEPTH), computed from registered count only.
  - When full, a retire in the same cycle does not enable an alloc; it is accepted next cycle.
- Complete:
  - When cmpl_valid and entry[cmpl_tag] is PENDING, store all cmpl_* fields; entry becomes DONE.
  - Completing a FREE or DONE entry: ignored, err set sticky until reset.
- Retire:
  - Decided from registered state at the start of the cycle: if entry[head] is DONE, the next edge does all of the following:
    - loads the rvfi_* outputs from entry[head] and sets rvfi_valid = 1;
    - sets rvfi_order to the counter, then increments the counter (wraps 255 -> 0);
    - frees the entry, increments head and decrements count.
  - Otherwise rvfi_valid = 0 and the other outputs hold their values.
  - At most one retirement per cycle. Latency from completion of the head entry to rvfi_valid is 1 cycle.
- Output rules:
  - rvfi_rd_wdata is forced to 0 whenever rvfi_rd_addr == 0.
  - When rvfi_trap = 1: rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_rmask and rvfi_mem_wmask are forced to 0.
- Simultaneous events:
  - Alloc, complete and retire in one cycle are all honoured; count changes by +1, 0 or -1.
  - Completion of the head tag in the same cycle as a retire check: the retire of that entry happens the following cycle.
- Flush:
  - Has priority over alloc, complete and retire in the same cycle.
  - All entries become FREE; head = tail = count = 0.
  - rvfi_valid = 0 next cycle.
  - Order counter is not reset; err is not cleared.
  - alloc_tag restarts at 0.
- Wrap-around: head and tail wrap mod DEPTH; full vs empty is distinguished by count, never by pointer equality.

Test Plan:
- In-order flow: alloc tags 0,1,2 then complete 0,1,2 on consecutive cycles -> rvfi_valid on 3 consecutive cycles, rvfi_order 0,1,2, rvfi_pre_pc matches the alloc order.
- Out-of-order completion: alloc 0..3, complete 3,2,1 then 0 -> no rvfi_valid until tag 0 completes; then 4 consecutive retirements with order 0..3.
- Full: allocate 8 (DEPTH=8) -> alloc_ready = 0. Complete tag 0 -> retire, and alloc_ready = 1 one cycle after the retire. The next alloc_tag = 0 (wrap).
- Flush: 5 pending entries, 2 DONE, flush asserted -> no retirement follows. Next alloc gets tag 0; its retirement carries rvfi_order = previous counter value.
- Field rules:
  - Completion with rd_addr = 0, rd_wdata = 0xDEADBEEF -> rvfi_rd_wdata = 0.
  - Trap completion with wmask = 0xF -> rvfi_trap = 1, rvfi_mem_wmask = 0.
- Error and wrap: complete a FREE tag -> err = 1 and stays high, with no state change. 256 retirements -> rvfi_order wraps from 255 to 0.
